seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter: STABLE_CYC, default 16, consecutive identical samples needed before capture (legal range 2..255).
REQ-002 SHALL have port: mclk  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: an  input  4  digit enables from a multiplexed 4-digit display driver, active-low, bit i = digit i.
REQ-005 SHALL have port: seg  input  8  segment drive, active-low, seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.
REQ-006 SHALL have port: digits  output  16  captured hex value per digit, digit i at [4i+3:4i].
REQ-007 SHALL have port: dp  output  4  captured decimal point per digit, 1 = lit.
REQ-008 SHALL have port: dig_valid  output  4  digit i captured at least once since reset.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse when all four digits are captured in the current frame.
REQ-010 SHALL have port: seg_err  output  1  one-cycle pulse when a stable segment pattern matches no hex glyph.
REQ-011 SHALL have port: an_err  output  1  one-cycle pulse when a stable an value has two or more zero bits.

Function
REQ-012 SHALL pass an and seg through a 2-flop synchronizer before any other use.
REQ-013 SHALL implement FSM IDLE, SETTLE, HELD on the synchronized {an,seg}.
REQ-014 SHALL move from IDLE to SETTLE, clearing the stability counter, on any change of {an,seg}.
REQ-015 SHALL in SETTLE increment the counter each cycle the sample equals the previous one, and return to SETTLE with counter 0 on any change.
REQ-016 SHALL on the cycle the counter reaches STABLE_CYC-1 perform a capture and enter HELD.
REQ-017 SHALL stay in HELD with no recapture until {an,seg} changes, then enter SETTLE.
REQ-018 SHALL make a value applied at the ports from cycle t and held visible on the outputs at exactly cycle t+STABLE_CYC+2.
REQ-019 SHALL on capture with an = all-ones treat the capture as idle: no update, no error.
REQ-020 SHALL on capture with exactly one zero in an decode seg[6:0] to hex using glyphs 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E (standard set for the rest), and write digits, dp and dig_valid for that digit.
REQ-021 SHALL on capture with an unknown glyph pulse seg_err and leave that digit's value, dp and frame mask unchanged.
REQ-022 SHALL on capture with two or more zeros in an pulse an_err and update nothing.
REQ-023 SHALL keep a 4-bit frame mask set by each good capture. When the mask becomes 4'b1111 it SHALL pulse frame_done that cycle and clear the mask to 0.
REQ-024 SHALL on recapture of a digit already in the mask overwrite its value and leave the mask unchanged.
REQ-025 SHALL size the counter as $clog2(STABLE_CYC), with no wrap: it saturates in HELD.

Reset
REQ-026 SHALL on rst clear digits, dp, dig_valid, frame mask, counter and synchronizers, and enter IDLE.
REQ-027 SHALL drive frame_done, seg_err and an_err to 0 during reset.
REQ-028 SHALL let reset mid-SETTLE discard the pending capture.

Configuration
REQ-029 SHALL support macro SEG_SCAN_BLANK_EN. When defined: output port blank (4 bits) is added, seg[6:0]=7'h7F captures as blank[i]=1 with digits unchanged, and the capture counts toward the frame mask. A good glyph capture clears blank[i]. Reset value of blank is 0.
REQ-030 SHALL without SEG_SCAN_BLANK_EN treat 7'h7F as an unknown glyph, pulsing seg_err.

Structure
REQ-031 SHALL have package seg_scan_pkg holding the FSM state enum, the 16 glyph constants and the idle an constant 4'hF.
REQ-032 SHALL have combinational sub-module seg7_to_hex: seg[6:0] in, hex[3:0] and hit out (plus is_blank under the macro).

Verification
REQ-033 SHALL test: rst, then an=4'b1110, seg=8'hC0 held 20 cycles -> digits[3:0]=0, dp[0]=0, dig_valid=4'b0001 at t+18.
REQ-034 SHALL test: scan an=E,D,B,7 with glyphs 1,2,3,A, each held 20 cycles -> digits=16'hA321, frame_done pulses once on the 4th capture.
REQ-035 SHALL test: glitch (one-cycle seg change every 10 cycles, STABLE_CYC=16) -> no capture, digits unchanged.
REQ-036 SHALL test: an=4'b1100 held 20 cycles -> an_err single pulse, no output update.
REQ-037 SHALL test: seg=8'hFF on digit 2 -> seg_err pulse without the macro, blank[2]=1 with SEG_SCAN_BLANK_EN.
REQ-038 SHALL test: rst asserted at counter=10 in SETTLE -> all outputs 0, no capture after release until restabilized.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_pkg                                                  |
// | Brief    : FSM state, active-low 7-segment glyph table and idle value    |
// |            shared by the segment scan decoder.                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package seg_scan_pkg;

    typedef enum logic [1:0] {
        c_st_idle   = 2'd0,
        c_st_settle = 2'd1,
        c_st_held   = 2'd2
    } state_t;

    localparam logic [3:0] c_an_idle   = 4'hF;
    localparam logic [6:0] c_seg_blank = 7'h7F;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a.
    localparam logic [6:0] c_glyph_0 = 7'h40;
    localparam logic [6:0] c_glyph_1 = 7'h79;
    localparam logic [6:0] c_glyph_2 = 7'h24;
    localparam logic [6:0] c_glyph_3 = 7'h30;
    localparam logic [6:0] c_glyph_4 = 7'h19;
    localparam logic [6:0] c_glyph_5 = 7'h12;
    localparam logic [6:0] c_glyph_6 = 7'h02;
    localparam logic [6:0] c_glyph_7 = 7'h78;
    localparam logic [6:0] c_glyph_8 = 7'h00;
    localparam logic [6:0] c_glyph_9 = 7'h10;
    localparam logic [6:0] c_glyph_a = 7'h08;
    localparam logic [6:0] c_glyph_b = 7'h03;
    localparam logic [6:0] c_glyph_c = 7'h46;
    localparam logic [6:0] c_glyph_d = 7'h21;
    localparam logic [6:0] c_glyph_e = 7'h06;
    localparam logic [6:0] c_glyph_f = 7'h0E;

    function automatic logic [2:0] zero_count(input logic [3:0] v);
        zero_count = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) zero_count = zero_count + 3'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_to_hex                                                   |
// | Brief    : Combinational active-low 7-segment pattern to hex decoder.    |
// |            SEG_SCAN_BLANK_EN adds the is_blank output.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
`ifdef SEG_SCAN_BLANK_EN
    output logic       is_blank,
`endif
    output logic       hit
);

    always_comb begin
        hex = 4'h0;
        hit = 1'b1;
        case (seg)
            c_glyph_0: hex = 4'h0;
            c_glyph_1: hex = 4'h1;
            c_glyph_2: hex = 4'h2;
            c_glyph_3: hex = 4'h3;
            c_glyph_4: hex = 4'h4;
            c_glyph_5: hex = 4'h5;
            c_glyph_6: hex = 4'h6;
            c_glyph_7: hex = 4'h7;
            c_glyph_8: hex = 4'h8;
            c_glyph_9: hex = 4'h9;
            c_glyph_a: hex = 4'hA;
            c_glyph_b: hex = 4'hB;
            c_glyph_c: hex = 4'hC;
            c_glyph_d: hex = 4'hD;
            c_glyph_e: hex = 4'hE;
            c_glyph_f: hex = 4'hF;
            default:   hit = 1'b0;
        endcase
    end

`ifdef SEG_SCAN_BLANK_EN
    assign is_blank = (seg == c_seg_blank);
`endif

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_decoder                                              |
// | Brief    : Recovers per-digit hex values from a multiplexed 4-digit      |
// |            7-segment drive. Optional SEG_SCAN_BLANK_EN adds blank[3:0].  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYC = 16
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  dig_valid,
    output logic        frame_done,
    output logic        seg_err,
`ifdef SEG_SCAN_BLANK_EN
    output logic [3:0]  blank,
`endif
    output logic        an_err
);

    localparam int                  c_cnt_w    = $clog2(STABLE_CYC);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_pen  = c_cnt_w'(STABLE_CYC - 2);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(STABLE_CYC - 1);

    logic [11:0]        r_sync1;
    logic [11:0]        r_sync2;
    logic [11:0]        r_prev;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [15:0]        r_digits;
    logic [3:0]         r_dp;
    logic [3:0]         r_valid;
    logic [3:0]         r_mask;
    logic               r_frame_done;
    logic               r_seg_err;
    logic               r_an_err;

    logic               w_changed;
    logic [3:0]         w_an;
    logic [7:0]         w_seg;
    logic [2:0]         w_zeros;
    logic [1:0]         w_idx;
    logic [3:0]         w_bit;
    logic [3:0]         w_mask_next;
    logic [3:0]         w_hex;
    logic               w_hit;
    logic               w_good;

    assign w_changed   = (r_sync2 != r_prev);
    assign w_an        = r_sync2[11:8];
    assign w_seg       = r_sync2[7:0];
    assign w_zeros     = zero_count(w_an);
    assign w_bit       = 4'b0001 << w_idx;
    assign w_mask_next = r_mask | w_bit;

    always_comb begin
        w_idx = 2'd0;
        case (w_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

`ifdef SEG_SCAN_BLANK_EN
    logic       w_is_blank;
    logic [3:0] r_blank;

    seg7_to_hex u_dec (
        .seg      (w_seg[6:0]),
        .hex      (w_hex),
        .is_blank (w_is_blank),
        .hit      (w_hit)
    );

    assign w_good = w_hit | w_is_blank;
    assign blank  = r_blank;
`else
    seg7_to_hex u_dec (
        .seg (w_seg[6:0]),
        .hex (w_hex),
        .hit (w_hit)
    );

    assign w_good = w_hit;
`endif

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_sync1      <= 12'h000;
            r_sync2      <= 12'h000;
            r_prev       <= 12'h000;
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_digits     <= 16'h0000;
            r_dp         <= 4'h0;
            r_valid      <= 4'h0;
            r_mask       <= 4'h0;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_an_err     <= 1'b0;
`ifdef SEG_SCAN_BLANK_EN
            r_blank      <= 4'h0;
`endif
        end else begin
            r_sync1      <= {an, seg};
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_frame_done <= 1'b0;
            r_seg_err    <= 1'b0;
            r_an_err     <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_changed) begin
                        r_state <= c_st_settle;
                        r_cnt   <= '0;
                    end
                end
                c_st_settle: begin
                    if (w_changed) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_pen) begin
                        r_cnt   <= c_cnt_last;
                        r_state <= c_st_held;
                        // Capture; an all-ones is a blanking gap between digits.
                        if (w_an != c_an_idle) begin
                            if (w_zeros != 3'd1) begin
                                r_an_err <= 1'b1;
                            end else if (!w_good) begin
                                r_seg_err <= 1'b1;
                            end else begin
                                r_valid[w_idx] <= 1'b1;
`ifdef SEG_SCAN_BLANK_EN
                                r_blank[w_idx] <= w_is_blank;
`endif
                                if (w_hit) begin
                                    r_digits[{w_idx, 2'b00} +: 4] <= w_hex;
                                    r_dp[w_idx]                   <= ~w_seg[7];
                                end
                                if (w_mask_next == 4'hF) begin
                                    r_frame_done <= 1'b1;
                                    r_mask       <= 4'h0;
                                end else begin
                                    r_mask <= w_mask_next;
                                end
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_held: begin
                    if (w_changed) begin
                        r_state <= c_st_settle;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign digits     = r_digits;
    assign dp         = r_dp;
    assign dig_valid  = r_valid;
    assign frame_done = r_frame_done;
    assign seg_err    = r_seg_err;
    assign an_err     = r_an_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg_scan_decoder                                           |
// | Brief    : Scoreboard bench for seg_scan_decoder (SEG_SCAN_BLANK_EN      |
// |            aware).                                                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_seg_scan_decoder;

    localparam int STABLE_CYC = 16;
    localparam int LAT        = STABLE_CYC + 2;

    logic        mclk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  dig_valid;
    logic        frame_done;
    logic        seg_err;
    logic        an_err;
    logic [3:0]  blank_w;

    seg_scan_decoder #(.STABLE_CYC(STABLE_CYC)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .an         (an),
        .seg        (seg),
        .digits     (digits),
        .dp         (dp),
        .dig_valid  (dig_valid),
        .frame_done (frame_done),
        .seg_err    (seg_err),
`ifdef SEG_SCAN_BLANK_EN
        .blank      (blank_w),
`endif
        .an_err     (an_err)
    );

`ifndef SEG_SCAN_BLANK_EN
    assign blank_w = 4'h0;
`endif

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic [3:0]  blank;
        logic        fd;
        logic        se;
        logic        ae;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any output change or pulse is a DUT event to match against the queue.
    logic [31:0] last_snap = 32'h0;
    always @(negedge mclk) begin : mon
        logic [31:0] snap;
        ev_t         e;
        snap = {4'h0, digits, dp, dig_valid, blank_w};
        if (rst) begin
            last_snap <= snap;
        end else begin
            if (snap != last_snap || frame_done || seg_err || an_err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got digits=%h dp=%b valid=%b fd=%b se=%b ae=%b, required no event (cycle %0d)",
                             digits, dp, dig_valid, frame_done, seg_err, an_err, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ev_cycle",  32'(cyc),        32'(e.cyc));
                    chk("ev_digits", 32'(digits),     32'(e.digits));
                    chk("ev_dp",     32'(dp),         32'(e.dp));
                    chk("ev_valid",  32'(dig_valid),  32'(e.valid));
                    chk("ev_pulses", 32'({frame_done, seg_err, an_err}), 32'({e.fd, e.se, e.ae}));
`ifdef SEG_SCAN_BLANK_EN
                    chk("ev_blank",  32'(blank_w),    32'(e.blank));
`endif
                end
            end
            last_snap <= snap;
        end
    end

    task automatic apply(input logic [3:0] a, input logic [7:0] s, input int hold,
                         input bit has_ev, input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] v, input logic [3:0] b,
                         input logic fd, input logic se, input logic ae);
        ev_t e;
        an  = a;
        seg = s;
        if (has_ev) begin
            e.cyc = cyc + LAT; e.digits = d; e.dp = p; e.valid = v; e.blank = b;
            e.fd = fd; e.se = se; e.ae = ae;
            sb.push_back(e);
        end
        repeat (hold) @(negedge mclk);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({digits, dp, dig_valid, blank_w, frame_done, seg_err, an_err}), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (3) @(negedge mclk);
        chk_all_zero("reset_state");
        rst = 1'b0;
        repeat (20) @(negedge mclk);

        // Single digit 0 on position 0.
        apply(4'b1110, 8'hC0, 20, 1, 16'h0000, 4'b0000, 4'b0001, 4'h0, 0, 0, 0);

        // Scan 1,2,3(dp),A over digits 0..3; recapture of digit 0 keeps the mask.
        apply(4'b1110, 8'hF9, 20, 1, 16'h0001, 4'b0000, 4'b0001, 4'h0, 0, 0, 0);
        apply(4'b1101, 8'hA4, 20, 1, 16'h0021, 4'b0000, 4'b0011, 4'h0, 0, 0, 0);
        apply(4'b1011, 8'h30, 20, 1, 16'h0321, 4'b0100, 4'b0111, 4'h0, 0, 0, 0);
        apply(4'b0111, 8'h88, 20, 1, 16'hA321, 4'b0100, 4'b1111, 4'h0, 1, 0, 0);

        // Glitch every 10 cycles never lets the pattern settle.
        for (int i = 0; i < 6; i++) begin
            apply(4'b1110, 8'hA4, 9, 0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
            apply(4'b1110, 8'hB0, 1, 0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        end
        apply(4'hF, 8'hFF, 20, 0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        chk("glitch_digits", 32'(digits),    32'h0000A321);
        chk("glitch_valid",  32'(dig_valid), 32'hF);

        // Two digits enabled at once.
        apply(4'b1100, 8'hC0, 20, 1, 16'hA321, 4'b0100, 4'b1111, 4'h0, 0, 0, 1);

        // All segments dark on digit 2.
`ifdef SEG_SCAN_BLANK_EN
        apply(4'b1011, 8'hFF, 20, 1, 16'hA321, 4'b0100, 4'b1111, 4'b0100, 0, 0, 0);
`else
        apply(4'b1011, 8'hFF, 20, 1, 16'hA321, 4'b0100, 4'b1111, 4'h0, 0, 1, 0);
`endif
        apply(4'hF, 8'hFF, 20, 0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);

        // Reset while the counter sits at 10 in SETTLE.
        apply(4'b1101, 8'hF9, 13, 0, 16'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
        rst = 1'b1;
        @(negedge mclk);
        chk_all_zero("mid_settle_reset");
        @(negedge mclk);
        rst = 1'b0;
        apply(4'b1101, 8'hF9, 22, 1, 16'h0010, 4'b0000, 4'b0010, 4'h0, 0, 0, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
